// File: rtl/game_state_controller_if.sv
// Key-event and random-generator handshakes between the game controller and its neighbours.
interface game_state_controller_if;
  logic [1:0]  iKeyState;
  logic        oKeyAck;
  logic [31:0] iRandom;
  logic        oRandomReset;

  modport master (output iKeyState, output iRandom, input oKeyAck, input oRandomReset);
  modport slave  (input iKeyState, input iRandom, output oKeyAck, output oRandomReset);
endinterface

// File: rtl/game_state_controller.sv
// Game flow (title/play/game-over) and per-frame bird/pipe physics feeding the renderer.
module game_state_controller #(
  parameter int BIRD_X       = 100,
  parameter int BIRD_W       = 34,
  parameter int BIRD_H       = 24,
  parameter int BIRD_Y0      = 216,
  parameter int GROUND_Y     = 480,
  parameter int GRAVITY      = 1,
  parameter int FLAP_SPEED   = 8,
  parameter int MAX_FALL     = 12,
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_SPACING = 160,
  parameter int PIPE_W       = 52,
  parameter int GAP_H        = 120,
  parameter int GAP_MIN      = 60
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iFrameTick,
  game_state_controller_if.slave bus,
  output logic [1:0]             oScreen,
  output logic [9:0]             oBirdY,
  output logic [9:0]             oPipe1X,
  output logic [9:0]             oPipe2X,
  output logic [9:0]             oPipe3X,
  output logic [8:0]             oPipe1Y,
  output logic [8:0]             oPipe2Y,
  output logic [8:0]             oPipe3Y,
  output logic [9:0]             oScore
);

  typedef enum logic [1:0] {
    S_TITLE = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2
  } screen_e;

  localparam logic [11:0] C_BIRD_X     = 12'(BIRD_X);
  localparam logic [11:0] C_BIRD_W     = 12'(BIRD_W);
  localparam logic [11:0] C_BIRD_H     = 12'(BIRD_H);
  localparam logic [11:0] C_GROUND_Y   = 12'(GROUND_Y);
  localparam logic [11:0] C_PIPE_SPEED = 12'(PIPE_SPEED);
  localparam logic [11:0] C_WRAP_ADD   = 12'(3 * PIPE_SPACING - PIPE_SPEED);
  localparam logic [11:0] C_PIPE_W     = 12'(PIPE_W);
  localparam logic [11:0] C_GAP_H      = 12'(GAP_H);
  localparam logic [8:0]  C_GAP_MIN    = 9'(GAP_MIN);
  localparam logic [9:0]  C_Y0         = 10'(BIRD_Y0);
  localparam logic [9:0]  C_Y_GROUND   = 10'(GROUND_Y - BIRD_H);
  localparam logic signed [6:0] C_GRAVITY  = 7'(GRAVITY);
  localparam logic signed [6:0] C_MAX_FALL = 7'(MAX_FALL);
  localparam logic signed [6:0] C_FLAP_VEL = 7'(-FLAP_SPEED);

  function automatic logic [9:0] init_x(input int idx);
    case (idx)
      0:       return 10'd320;
      1:       return 10'd480;
      default: return 10'd640;
    endcase
  endfunction

  function automatic logic [8:0] init_gap(input int idx);
    case (idx)
      0:       return 9'd100;
      1:       return 9'd200;
      default: return 9'd300;
    endcase
  endfunction

  screen_e           screen_q, screen_d;
  logic [9:0]        bird_y_q, bird_y_d;
  logic signed [6:0] vel_q, vel_d;
  logic [9:0]        pipe_x_q [3];
  logic [9:0]        pipe_x_d [3];
  logic [8:0]        gap_y_q [3];
  logic [8:0]        gap_y_d [3];
  logic [9:0]        score_q, score_d;
  logic              flap_q, flap_d;
  logic              key_ack_q, key_ack_d;
  logic              rnd_rst_q, rnd_rst_d;

  logic              key_ev_s, press_s;
  logic signed [6:0] vel_grav_s, vel_tick_s;
  logic signed [11:0] y_sum_s;
  logic [9:0]        pipe_x_new_s [3];
  logic [8:0]        gap_new_s [3];
  logic [2:0]        passed_s, pipe_hit_s;
  logic [11:0]       score_sum_s;
  logic [9:0]        score_new_s;
  logic              ground_hit_s, hit_s;

  assign key_ev_s = (bus.iKeyState != 2'd0) && !key_ack_q;
  assign press_s  = key_ev_s && (bus.iKeyState == 2'd1);

  // Candidate physics step and collision status, both derived from registered state.
  always_comb begin
    vel_grav_s   = vel_q + C_GRAVITY;
    if (vel_grav_s > C_MAX_FALL) begin
      vel_grav_s = C_MAX_FALL;
    end else begin
      vel_grav_s = vel_grav_s;
    end
    vel_tick_s   = (flap_q || press_s) ? C_FLAP_VEL : vel_grav_s;
    y_sum_s      = $signed({2'b00, bird_y_q}) + 12'(vel_tick_s);
    ground_hit_s = ({2'b00, bird_y_q} + C_BIRD_H) >= C_GROUND_Y;
    for (int i = 0; i < 3; i++) begin
      if ({2'b00, pipe_x_q[i]} < C_PIPE_SPEED) begin
        pipe_x_new_s[i] = 10'({2'b00, pipe_x_q[i]} + C_WRAP_ADD);
        gap_new_s[i]    = C_GAP_MIN + {1'b0, bus.iRandom[8*i +: 8]};
        passed_s[i]     = 1'b0;
      end else begin
        pipe_x_new_s[i] = 10'({2'b00, pipe_x_q[i]} - C_PIPE_SPEED);
        gap_new_s[i]    = gap_y_q[i];
        passed_s[i]     = ({2'b00, pipe_x_q[i]} >= C_BIRD_X) &&
                          ({2'b00, pipe_x_q[i]} - C_PIPE_SPEED < C_BIRD_X);
      end
      // Overlap in X, and the bird's full height is not within the gap.
      pipe_hit_s[i] = (C_BIRD_X < {2'b00, pipe_x_q[i]} + C_PIPE_W) &&
                      ({2'b00, pipe_x_q[i]} < C_BIRD_X + C_BIRD_W) &&
                      !(({2'b00, bird_y_q} >= {3'b000, gap_y_q[i]}) &&
                        ({2'b00, bird_y_q} + C_BIRD_H <= {3'b000, gap_y_q[i]} + C_GAP_H));
    end
    hit_s       = ground_hit_s || (pipe_hit_s != 3'd0);
    score_sum_s = {2'b00, score_q} + {11'd0, passed_s[0]} + {11'd0, passed_s[1]} +
                  {11'd0, passed_s[2]};
    score_new_s = (score_sum_s > 12'd999) ? 10'd999 : score_sum_s[9:0];
  end

  // Screen FSM next state plus physics register updates.
  always_comb begin
    screen_d  = screen_q;
    bird_y_d  = bird_y_q;
    vel_d     = vel_q;
    score_d   = score_q;
    flap_d    = flap_q;
    key_ack_d = key_ev_s;
    rnd_rst_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pipe_x_d[i] = pipe_x_q[i];
      gap_y_d[i]  = gap_y_q[i];
    end
    case (screen_q)
      S_TITLE: begin
        if (press_s) begin
          screen_d  = S_PLAY;
          rnd_rst_d = 1'b1;
          bird_y_d  = C_Y0;
          vel_d     = 7'sd0;
          score_d   = 10'd0;
          flap_d    = 1'b0;
          for (int i = 0; i < 3; i++) begin
            pipe_x_d[i] = init_x(i);
            gap_y_d[i]  = init_gap(i);
          end
        end else begin
          screen_d = S_TITLE;
        end
      end
      S_PLAY: begin
        if (hit_s) begin
          screen_d = S_OVER;
          flap_d   = 1'b0;
          if (ground_hit_s) begin
            bird_y_d = C_Y_GROUND;
          end else begin
            bird_y_d = bird_y_q;
          end
        end else if (iFrameTick) begin
          flap_d  = 1'b0;
          score_d = score_new_s;
          if (y_sum_s[11]) begin
            bird_y_d = 10'd0;
            vel_d    = 7'sd0;
          end else begin
            bird_y_d = y_sum_s[9:0];
            vel_d    = vel_tick_s;
          end
          for (int i = 0; i < 3; i++) begin
            pipe_x_d[i] = pipe_x_new_s[i];
            gap_y_d[i]  = gap_new_s[i];
          end
        end else if (press_s) begin
          flap_d = 1'b1;
        end else begin
          flap_d = flap_q;
        end
      end
      S_OVER: begin
        if (press_s) begin
          screen_d = S_TITLE;
        end else begin
          screen_d = S_OVER;
        end
      end
      default: screen_d = S_TITLE;
    endcase
  end

  // State registers with synchronous reset to the title-screen values.
  always_ff @(posedge clock) begin
    if (reset) begin
      screen_q  <= S_TITLE;
      bird_y_q  <= C_Y0;
      vel_q     <= 7'sd0;
      score_q   <= 10'd0;
      flap_q    <= 1'b0;
      key_ack_q <= 1'b0;
      rnd_rst_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pipe_x_q[i] <= init_x(i);
        gap_y_q[i]  <= init_gap(i);
      end
    end else begin
      screen_q  <= screen_d;
      bird_y_q  <= bird_y_d;
      vel_q     <= vel_d;
      score_q   <= score_d;
      flap_q    <= flap_d;
      key_ack_q <= key_ack_d;
      rnd_rst_q <= rnd_rst_d;
      for (int i = 0; i < 3; i++) begin
        pipe_x_q[i] <= pipe_x_d[i];
        gap_y_q[i]  <= gap_y_d[i];
      end
    end
  end

  assign oScreen          = screen_q;
  assign oBirdY           = bird_y_q;
  assign oPipe1X          = pipe_x_q[0];
  assign oPipe2X          = pipe_x_q[1];
  assign oPipe3X          = pipe_x_q[2];
  assign oPipe1Y          = gap_y_q[0];
  assign oPipe2Y          = gap_y_q[1];
  assign oPipe3Y          = gap_y_q[2];
  assign oScore           = score_q;
  assign bus.oKeyAck      = key_ack_q;
  assign bus.oRandomReset = rnd_rst_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: a behavioural model fills a scoreboard every cycle.
module tb_game_state_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       iFrameTick;
  logic [1:0] oScreen;
  logic [9:0] oBirdY, oPipe1X, oPipe2X, oPipe3X, oScore;
  logic [8:0] oPipe1Y, oPipe2Y, oPipe3Y;

  game_state_controller_if bus ();

  game_state_controller dut (
    .clock     (clock),
    .reset     (reset),
    .iFrameTick(iFrameTick),
    .bus       (bus),
    .oScreen   (oScreen),
    .oBirdY    (oBirdY),
    .oPipe1X   (oPipe1X),
    .oPipe2X   (oPipe2X),
    .oPipe3X   (oPipe3X),
    .oPipe1Y   (oPipe1Y),
    .oPipe2Y   (oPipe2Y),
    .oPipe3Y   (oPipe3Y),
    .oScore    (oScore)
  );

  typedef struct packed {
    logic [1:0] scr;
    logic [9:0] y;
    logic [9:0] p1x, p2x, p3x;
    logic [8:0] g1, g2, g3;
    logic [9:0] score;
    logic       ack;
    logic       rr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int m_scr, m_y, m_vel, m_score, m_flap, m_ack, m_rr;
  int m_px[3];
  int m_gy[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_init();
    m_y = 216; m_vel = 0; m_score = 0; m_flap = 0;
    m_px[0] = 320; m_px[1] = 480; m_px[2] = 640;
    m_gy[0] = 100; m_gy[1] = 200; m_gy[2] = 300;
  endtask

  task automatic model_step(input bit tick, input int key, input logic [31:0] rnd, input bit rst);
    int ev, pr, hit, gh, nv, ny;
    if (rst) begin
      m_scr = 0; m_ack = 0; m_rr = 0;
      model_init();
    end else begin
      ev = (key != 0 && m_ack == 0) ? 1 : 0;
      pr = (ev == 1 && key == 1) ? 1 : 0;
      m_rr = 0;
      if (m_scr == 0) begin
        if (pr == 1) begin
          m_scr = 1; m_rr = 1;
          model_init();
        end
      end else if (m_scr == 1) begin
        gh  = (m_y + 24 >= 480) ? 1 : 0;
        hit = gh;
        for (int i = 0; i < 3; i++) begin
          if (m_px[i] + 52 > 100 && m_px[i] < 134 &&
              !(m_y >= m_gy[i] && m_y + 24 <= m_gy[i] + 120)) hit = 1;
        end
        if (hit == 1) begin
          m_scr = 2; m_flap = 0;
          if (gh == 1) m_y = 456;
        end else if (tick) begin
          nv = (m_flap == 1 || pr == 1) ? -8 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
          ny = m_y + nv;
          if (ny < 0) begin ny = 0; nv = 0; end
          m_y = ny; m_vel = nv; m_flap = 0;
          for (int i = 0; i < 3; i++) begin
            if (m_px[i] < 2) begin
              m_px[i] = m_px[i] + 478;
              m_gy[i] = 60 + int'((rnd >> (8 * i)) & 32'hFF);
            end else begin
              if (m_px[i] >= 100 && m_px[i] - 2 < 100) m_score++;
              m_px[i] = m_px[i] - 2;
            end
          end
          if (m_score > 999) m_score = 999;
        end else if (pr == 1) begin
          m_flap = 1;
        end
      end else if (m_scr == 2) begin
        if (pr == 1) m_scr = 0;
      end
      m_ack = ev;
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_screen", 32'(oScreen), 32'(e.scr));
      chk("sb_bird_y", 32'(oBirdY), 32'(e.y));
      chk("sb_pipe1_x", 32'(oPipe1X), 32'(e.p1x));
      chk("sb_pipe2_x", 32'(oPipe2X), 32'(e.p2x));
      chk("sb_pipe3_x", 32'(oPipe3X), 32'(e.p3x));
      chk("sb_pipe1_y", 32'(oPipe1Y), 32'(e.g1));
      chk("sb_pipe2_y", 32'(oPipe2Y), 32'(e.g2));
      chk("sb_pipe3_y", 32'(oPipe3Y), 32'(e.g3));
      chk("sb_score", 32'(oScore), 32'(e.score));
      chk("sb_key_ack", 32'(bus.oKeyAck), 32'(e.ack));
      chk("sb_rnd_reset", 32'(bus.oRandomReset), 32'(e.rr));
    end
  endtask

  task automatic step(input bit tick, input logic [1:0] key, input logic [31:0] rnd, input bit rst);
    exp_t e;
    reset = rst; iFrameTick = tick; bus.iKeyState = key; bus.iRandom = rnd;
    model_step(tick, int'(key), rnd, rst);
    e.scr = 2'(m_scr); e.y = 10'(m_y);
    e.p1x = 10'(m_px[0]); e.p2x = 10'(m_px[1]); e.p3x = 10'(m_px[2]);
    e.g1 = 9'(m_gy[0]); e.g2 = 9'(m_gy[1]); e.g3 = 9'(m_gy[2]);
    e.score = 10'(m_score); e.ack = m_ack[0]; e.rr = m_rr[0];
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    reset = 1'b0; iFrameTick = 1'b0; bus.iKeyState = 2'd0;
    check_out();
  endtask

  task automatic tick_pair(input bit press);
    step(1'b1, press ? 2'd1 : 2'd0, $urandom, 1'b0);
    step(1'b0, 2'd0, $urandom, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    bit sc, wr, seen_score, seen_wrap, seen_hit;
    int fy;
    reset = 1'b1; iFrameTick = 1'b0; bus.iKeyState = 2'd0; bus.iRandom = 32'd0;
    seen_score = 1'b0; seen_wrap = 1'b0; seen_hit = 1'b0;

    step(1'b0, 2'd0, 32'd0, 1'b1);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("rst_screen", 32'(oScreen), 32'd0);
    chk("rst_bird_y", 32'(oBirdY), 32'd216);
    chk("rst_pipe_x", {2'b0, oPipe1X, oPipe2X, oPipe3X}, {2'b0, 10'd320, 10'd480, 10'd640});
    chk("rst_gap_y", {5'b0, oPipe1Y, oPipe2Y, oPipe3Y}, {5'b0, 9'd100, 9'd200, 9'd300});
    chk("rst_score", 32'(oScore), 32'd0);

    // Title -> play, then the handshake pulses drop.
    step(1'b0, 2'd1, $urandom, 1'b0);
    chk("start_screen", 32'(oScreen), 32'd1);
    chk("start_ack", 32'(bus.oKeyAck), 32'd1);
    chk("start_rnd_reset", 32'(bus.oRandomReset), 32'd1);
    step(1'b0, 2'd2, $urandom, 1'b0);
    chk("ack_pulse_end", 32'(bus.oKeyAck), 32'd0);
    chk("rr_pulse_end", 32'(bus.oRandomReset), 32'd0);
    step(1'b0, 2'd2, $urandom, 1'b0);
    chk("release_ack", 32'(bus.oKeyAck), 32'd1);
    chk("release_screen", 32'(oScreen), 32'd1);
    step(1'b0, 2'd0, $urandom, 1'b0);

    tick_pair(1'b0); chk("grav_y1", 32'(oBirdY), 32'd217);
    tick_pair(1'b0); chk("grav_y2", 32'(oBirdY), 32'd219);
    tick_pair(1'b0); chk("grav_y3", 32'(oBirdY), 32'd222);
    for (int k = 0; k < 12; k++) tick_pair(1'b0);
    chk("max_fall_y", 32'(oBirdY), 32'd330);

    // Hover above 150 through pipe 1 until pipe 2 (gap at 200) strikes the bird.
    for (int n = 0; n < 400 && m_scr == 1; n++) begin
      r  = $urandom;
      sc = (m_px[0] == 100);
      wr = (m_px[0] == 0);
      if (wr) r = 32'h0000_00FF;
      step(1'b1, (m_y >= 150) ? 2'd1 : 2'd0, r, 1'b0);
      if (sc) begin
        seen_score = 1'b1;
        chk("pass_pipe1_x", 32'(oPipe1X), 32'd98);
        chk("pass_score", 32'(oScore), 32'd1);
      end
      if (wr) begin
        seen_wrap = 1'b1;
        chk("wrap_pipe1_x", 32'(oPipe1X), 32'd478);
        chk("wrap_pipe1_gap", 32'(oPipe1Y), 32'd315);
      end
      step(1'b0, 2'd0, $urandom, 1'b0);
      if (m_scr == 2) begin
        seen_hit = 1'b1;
        chk("pipe_hit_screen", 32'(oScreen), 32'd2);
        chk("pipe_hit_pipe2_x", 32'(oPipe2X), 32'd132);
      end
    end
    chk("score_seen", 32'(seen_score), 32'd1);
    chk("wrap_seen", 32'(seen_wrap), 32'd1);
    chk("pipe_hit_seen", 32'(seen_hit), 32'd1);

    fy = m_y;
    for (int k = 0; k < 3; k++) tick_pair(1'b0);
    chk("frozen_y", 32'(oBirdY), 32'(fy));
    chk("frozen_score", 32'(oScore), 32'd1);

    step(1'b0, 2'd1, $urandom, 1'b0);
    chk("over_to_title", 32'(oScreen), 32'd0);
    step(1'b0, 2'd0, $urandom, 1'b0);
    step(1'b0, 2'd1, $urandom, 1'b0);
    chk("restart_screen", 32'(oScreen), 32'd1);
    chk("restart_score", 32'(oScore), 32'd0);
    step(1'b0, 2'd0, $urandom, 1'b0);

    tick_pair(1'b1); chk("flap_y", 32'(oBirdY), 32'd208);
    tick_pair(1'b0); chk("after_flap_y", 32'(oBirdY), 32'd201);

    seen_hit = 1'b0;
    for (int n = 0; n < 100 && m_scr == 1; n++) tick_pair(1'b0);
    chk("ground_screen", 32'(oScreen), 32'd2);
    chk("ground_clamp_y", 32'(oBirdY), 32'd456);

    step(1'b0, 2'd1, $urandom, 1'b0);
    step(1'b0, 2'd0, $urandom, 1'b0);
    step(1'b0, 2'd1, $urandom, 1'b0);
    step(1'b0, 2'd0, $urandom, 1'b0);
    tick_pair(1'b0);
    chk("replay_y", 32'(oBirdY), 32'd217);

    // Reset overrides a simultaneous tick and press.
    step(1'b1, 2'd1, $urandom, 1'b1);
    chk("mid_rst_screen", 32'(oScreen), 32'd0);
    chk("mid_rst_y", 32'(oBirdY), 32'd216);
    chk("mid_rst_pipe1_x", 32'(oPipe1X), 32'd320);
    chk("mid_rst_ack", 32'(bus.oKeyAck), 32'd0);
    chk("mid_rst_rr", 32'(bus.oRandomReset), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
